// File: rtl/pc_target_table.sv
// Programmable branch-target table: registered lookup (latency 1) with absolute or
// PC-relative entries, run-time writes with same-cycle forwarding and a clear sweep.
module pc_target_table #(
    parameter int D     = 12,
    parameter int A     = 8,
    parameter int DEPTH = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         lookup,
    input  logic [A-1:0] addr,
    input  logic [D-1:0] pc_in,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_target,
    input  logic         wr_rel,
    input  logic         clear,
    output logic         busy,
    output logic         rd_valid,
    output logic         hit,
    output logic [D-1:0] target,
    output logic         dbg_state
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0]    DEPTH_W = (A + 1)'(DEPTH);
    localparam logic [IW-1:0] LAST    = IW'(DEPTH - 1);

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

    // Handshake: lookup has no ready; a request in cycle N is answered by a
    // one-cycle rd_valid pulse in N+1. Writes are accepted only while busy=0.

    state_t                  state_q, state_d;
    logic [IW-1:0]           cnt_q, cnt_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [DEPTH-1:0]        rel_q, rel_d;
    logic [DEPTH-1:0][D-1:0] tgt_q, tgt_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    hit_q, hit_d;
    logic [D-1:0]            target_q, target_d;

    logic          in_rng;
    logic          wr_ok;
    logic          fwd;
    logic [IW-1:0] idx;
    logic [IW-1:0] widx;
    logic          e_vld;
    logic          e_rel;
    logic [D-1:0]  e_tgt;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vld_d      = vld_q;
        rel_d      = rel_q;
        tgt_d      = tgt_q;
        rd_valid_d = lookup;
        hit_d      = hit_q;
        target_d   = target_q;

        idx    = addr[IW-1:0];
        widx   = wr_addr[IW-1:0];
        in_rng = {1'b0, addr} < DEPTH_W;
        // clear wins over a same-cycle write
        wr_ok  = wr_en && (state_q == IDLE) && !clear && ({1'b0, wr_addr} < DEPTH_W);
        fwd    = wr_ok && (wr_addr == addr);

        e_vld = fwd ? 1'b1      : vld_q[idx];
        e_rel = fwd ? wr_rel    : rel_q[idx];
        e_tgt = fwd ? wr_target : tgt_q[idx];

        if (lookup) begin
            hit_d    = (state_q == IDLE) && in_rng && e_vld;
            target_d = pc_in;
            if (hit_d) begin
                target_d = e_rel ? (pc_in + e_tgt) : e_tgt;
            end
        end

        if (wr_ok) begin
            vld_d[widx] = 1'b1;
            rel_d[widx] = wr_rel;
            tgt_d[widx] = wr_target;
        end

        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                vld_d[cnt_q] = 1'b0;
                cnt_d        = cnt_q + IW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            vld_q      <= '0;
            rel_q      <= '0;
            tgt_q      <= '0;
            rd_valid_q <= 1'b0;
            hit_q      <= 1'b0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            vld_q      <= vld_d;
            rel_q      <= rel_d;
            tgt_q      <= tgt_d;
            rd_valid_q <= rd_valid_d;
            hit_q      <= hit_d;
            target_q   <= target_d;
        end
    end

    assign busy      = (state_q == CLEAR);
    assign dbg_state = state_q;
    assign rd_valid  = rd_valid_q;
    assign hit       = hit_q;
    assign target    = target_q;

endmodule

// File: tb/tb_pc_target_table.sv
// Bench for pc_target_table: directed vector table, clear/reset corner sequences and
// randomized traffic checked against a table-level reference model.
module tb_pc_target_table;

  localparam int D     = 12;
  localparam int A     = 8;
  localparam int DEPTH = 16;

  logic         Clk;
  logic         Reset_n;
  logic         lookup;
  logic [A-1:0] addr;
  logic [D-1:0] pc_in;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_target;
  logic         wr_rel;
  logic         clear;
  logic         busy;
  logic         rd_valid;
  logic         hit;
  logic [D-1:0] target;
  logic         dbg_state;

  pc_target_table #(.D(D), .A(A), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .lookup(lookup), .addr(addr), .pc_in(pc_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_target(wr_target), .wr_rel(wr_rel),
    .clear(clear), .busy(busy), .rd_valid(rd_valid), .hit(hit), .target(target),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // reference model: table contents plus remaining sweep cycles
  logic         m_vld [DEPTH];
  logic         m_rel [DEPTH];
  logic [D-1:0] m_tgt [DEPTH];
  int           m_busy_left;
  logic         m_rd;
  logic         m_hit;
  logic [D-1:0] m_target;

  int n_vec;
  int n_err;

  typedef struct {
    logic         lookup;
    logic [A-1:0] addr;
    logic [D-1:0] pc_in;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [D-1:0] wr_target;
    logic         wr_rel;
    logic         clear;
    logic         chk;
    logic         exp_hit;
    logic [D-1:0] exp_target;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_rel[i] = 1'b0;
      m_tgt[i] = '0;
    end
    m_busy_left = 0;
    m_rd        = 1'b0;
    m_hit       = 1'b0;
    m_target    = '0;
  endtask

  task automatic idle_inputs();
    lookup = 0; addr = '0; pc_in = '0; wr_en = 0; wr_addr = '0;
    wr_target = '0; wr_rel = 0; clear = 0;
  endtask

  // driver: inputs already applied; predict, clock once, compare
  task automatic step();
    logic         busy_now;
    logic         wr_ok;
    logic         v;
    logic         r;
    logic [D-1:0] t;
    busy_now = (m_busy_left > 0);
    wr_ok    = wr_en && !busy_now && !clear && (int'(wr_addr) < DEPTH);
    m_rd     = lookup;
    if (lookup) begin
      if (busy_now || int'(addr) >= DEPTH) begin
        m_hit    = 1'b0;
        m_target = pc_in;
      end else begin
        if (wr_ok && wr_addr == addr) begin
          v = 1'b1; r = wr_rel; t = wr_target;
        end else begin
          v = m_vld[addr]; r = m_rel[addr]; t = m_tgt[addr];
        end
        m_hit    = v;
        m_target = !v ? pc_in : (r ? D'(pc_in + t) : t);
      end
    end
    if (wr_ok) begin
      m_vld[wr_addr] = 1'b1;
      m_rel[wr_addr] = wr_rel;
      m_tgt[wr_addr] = wr_target;
    end
    // the whole table reads as invalid from the moment a sweep starts
    if (busy_now) m_busy_left--;
    else if (clear) begin
      m_busy_left = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
    end
    @(posedge Clk);
    #1;
    check("busy", busy, m_busy_left > 0);
    check("rd_valid", rd_valid, m_rd);
    check("hit", hit, m_hit);
    check("target", target, m_target);
    check("dbg_state", dbg_state, busy);
  endtask

  task automatic apply(input vec_t v);
    lookup = v.lookup; addr = v.addr; pc_in = v.pc_in; wr_en = v.wr_en;
    wr_addr = v.wr_addr; wr_target = v.wr_target; wr_rel = v.wr_rel; clear = v.clear;
    step();
    if (v.chk) begin
      check("tbl_rd_valid", rd_valid, 1'b1);
      check("tbl_hit", hit, v.exp_hit);
      check("tbl_target", target, v.exp_target);
    end
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_hit", hit, 1'b0);
    check("rst_target", target, 0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
  endtask

  function automatic vec_t mk(input logic lk, input int a, input int pc, input logic we,
                              input int wa, input int wt, input logic wrel, input logic clr,
                              input logic chk, input logic eh, input int et);
    vec_t v;
    v.lookup = lk; v.addr = A'(a); v.pc_in = D'(pc); v.wr_en = we; v.wr_addr = A'(wa);
    v.wr_target = D'(wt); v.wr_rel = wrel; v.clear = clr; v.chk = chk;
    v.exp_hit = eh; v.exp_target = D'(et);
    return v;
  endfunction

  int busy_cnt;

  initial begin
    n_vec = 0;
    n_err = 0;
    Reset_n = 1'b1;
    idle_inputs();
    model_reset();
    do_reset();

    // directed vectors
    vecs.push_back(mk(1, 3,   40,  0, 0, 0,   0, 0, 1, 0, 40));
    vecs.push_back(mk(0, 0,   0,   1, 1, 17,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1,   5,   0, 0, 0,   0, 0, 1, 1, 17));
    vecs.push_back(mk(0, 0,   0,   1, 2, -3,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2,   10,  0, 0, 0,   0, 0, 1, 1, 7));
    vecs.push_back(mk(1, 2,   1,   0, 0, 0,   0, 0, 1, 1, 4094));
    vecs.push_back(mk(1, 4,   9,   1, 4, 76,  0, 0, 1, 1, 76));
    vecs.push_back(mk(1, 5,   100, 1, 5, 20,  1, 0, 1, 1, 120));
    vecs.push_back(mk(1, 200, 123, 0, 0, 0,   0, 0, 1, 0, 123));
    vecs.push_back(mk(0, 4,   55,  1, 16, 9,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0,   77,  0, 0, 0,   0, 0, 1, 0, 77));
    vecs.push_back(mk(1, 6,   8,   1, 6, 3,   0, 1, 1, 0, 8));
    foreach (vecs[i]) apply(vecs[i]);
    idle_inputs();
    for (int i = 0; i < DEPTH + 2; i++) step();

    // fill table, sweep, count busy cycles, mid-sweep write and lookups
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      wr_en = 1; wr_addr = A'(i); wr_target = D'(i * 7 + 1); wr_rel = i[0];
      step();
    end
    idle_inputs();
    clear = 1;
    step();
    busy_cnt = busy ? 1 : 0;
    clear = 1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (i == 1) clear = 0;
      lookup = 1; addr = A'(i % DEPTH); pc_in = D'(300 + i);
      wr_en = (i == 3); wr_addr = 5; wr_target = 99; wr_rel = 0;
      step();
      if (busy) busy_cnt++;
    end
    check("sweep_busy_cycles", busy_cnt, DEPTH);
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      lookup = 1; addr = A'(i); pc_in = D'(1000 + i);
      step();
      check("post_sweep_miss", hit, 1'b0);
    end

    // reset in the middle of a sweep
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1; wr_addr = A'(i); wr_target = D'(50 + i);
      step();
    end
    idle_inputs();
    clear = 1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      lookup = 1; addr = A'(i); pc_in = D'(i + 9);
      step();
    end
    // reset with live entries also invalidates them
    idle_inputs();
    wr_en = 1; wr_addr = 7; wr_target = 123;
    step();
    do_reset();
    lookup = 1; addr = 7; pc_in = 66;
    step();
    check("reset_invalidates", hit, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      lookup    = ($urandom_range(0, 3) != 0);
      addr      = ($urandom_range(0, 15) == 0) ? A'($urandom_range(0, 255)) : A'($urandom_range(0, 19));
      pc_in     = D'($urandom);
      wr_en     = ($urandom_range(0, 2) == 0);
      wr_addr   = ($urandom_range(0, 3) == 0) ? addr : A'($urandom_range(0, 19));
      wr_target = D'($urandom);
      wr_rel    = $urandom_range(0, 1);
      clear     = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
